// File: rtl/demux_2_stream_pkg.sv
// Shared types and constants for the 1-to-2 packet-aware stream demultiplexer.
package demux_pkg;
  localparam int DEMUX_DW_DEFAULT = 16;
  localparam int STATS_W          = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROUTE0 = 2'd1,
    ROUTE1 = 2'd2
  } state_t;
endpackage

// File: rtl/demux_2_stream_if.sv
// Handshake bundle for demux_2_stream: one input stream and two output streams.
interface demux_2_stream_if import demux_pkg::*; #(parameter int data_width = DEMUX_DW_DEFAULT);
  logic                  in_valid;
  logic                  in_ready;
  logic [data_width-1:0] in_data;
  logic                  in_last;
  logic                  in_sel;
  logic                  out0_valid;
  logic                  out0_ready;
  logic [data_width-1:0] out0_data;
  logic                  out0_last;
  logic                  out1_valid;
  logic                  out1_ready;
  logic [data_width-1:0] out1_data;
  logic                  out1_last;

  // The demultiplexer's view.
  modport slave (
    input  in_valid, in_data, in_last, in_sel, out0_ready, out1_ready,
    output in_ready, out0_valid, out0_data, out0_last, out1_valid, out1_data, out1_last
  );

  // The surrounding producer/sink view.
  modport master (
    output in_valid, in_data, in_last, in_sel, out0_ready, out1_ready,
    input  in_ready, out0_valid, out0_data, out0_last, out1_valid, out1_data, out1_last
  );
endinterface

// File: rtl/demux_2_stream_out_slot.sv
// One-entry output register slice: load, drain, or replace-on-drain with no bubble.
module out_slot import demux_pkg::*; #(
  parameter int data_width = DEMUX_DW_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [data_width-1:0] load_data,
  input  logic                  load_last,
  input  logic                  out_ready,
  output logic                  valid,
  output logic [data_width-1:0] data,
  output logic                  last,
  output logic                  ready
);
  logic                  valid_r;
  logic [data_width-1:0] data_r;
  logic                  last_r;

  // Slot register; a load wins over a drain so a simultaneous pair keeps valid high.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_r <= 1'b0;
      data_r  <= {data_width{1'b0}};
      last_r  <= 1'b0;
    end else if (load) begin
      valid_r <= 1'b1;
      data_r  <= load_data;
      last_r  <= load_last;
    end else if (out_ready) begin
      valid_r <= 1'b0;
    end
  end

  assign valid = valid_r;
  assign data  = data_r;
  assign last  = last_r;
  assign ready = !valid_r || out_ready;
endmodule

// File: rtl/demux_2_stream.sv
// 1-to-2 packet-aware stream demux; destination locks on the first beat until in_last.
// Optional per-port beat/packet counters are built when DEMUX_STATS_EN is defined.
module demux_2_stream import demux_pkg::*; #(
  parameter int data_width = DEMUX_DW_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  demux_2_stream_if.slave    bus
`ifdef DEMUX_STATS_EN
  ,
  output logic [STATS_W-1:0] beats0,
  output logic [STATS_W-1:0] beats1,
  output logic [STATS_W-1:0] pkts0,
  output logic [STATS_W-1:0] pkts1
`endif
);
  state_t state_r;
  state_t state_next_s;
  logic   dest_s;
  logic   rdy0_s;
  logic   rdy1_s;
  logic   in_ready_s;
  logic   xfer_s;
  logic   load0_s;
  logic   load1_s;

  assign in_ready_s   = dest_s ? rdy1_s : rdy0_s;
  assign bus.in_ready = in_ready_s;
  assign xfer_s       = bus.in_valid && in_ready_s;
  assign load0_s      = xfer_s && !dest_s;
  assign load1_s      = xfer_s && dest_s;

  // Destination select and next-state logic.
  always_comb begin
    dest_s       = 1'b0;
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        dest_s = bus.in_sel;
        if (xfer_s && !bus.in_last) begin
          state_next_s = bus.in_sel ? ROUTE1 : ROUTE0;
        end else begin
          state_next_s = IDLE;
        end
      end
      ROUTE0: begin
        dest_s = 1'b0;
        if (xfer_s && bus.in_last) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = ROUTE0;
        end
      end
      ROUTE1: begin
        dest_s = 1'b1;
        if (xfer_s && bus.in_last) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = ROUTE1;
        end
      end
      default: begin
        dest_s       = 1'b0;
        state_next_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  out_slot #(.data_width(data_width)) u_slot0 (
    .clk       (clk),
    .reset     (reset),
    .load      (load0_s),
    .load_data (bus.in_data),
    .load_last (bus.in_last),
    .out_ready (bus.out0_ready),
    .valid     (bus.out0_valid),
    .data      (bus.out0_data),
    .last      (bus.out0_last),
    .ready     (rdy0_s)
  );

  out_slot #(.data_width(data_width)) u_slot1 (
    .clk       (clk),
    .reset     (reset),
    .load      (load1_s),
    .load_data (bus.in_data),
    .load_last (bus.in_last),
    .out_ready (bus.out1_ready),
    .valid     (bus.out1_valid),
    .data      (bus.out1_data),
    .last      (bus.out1_last),
    .ready     (rdy1_s)
  );

`ifdef DEMUX_STATS_EN
  logic [STATS_W-1:0] beats0_r;
  logic [STATS_W-1:0] beats1_r;
  logic [STATS_W-1:0] pkts0_r;
  logic [STATS_W-1:0] pkts1_r;

  // Output-side counters, wrapping naturally at 2^16.
  always_ff @(posedge clk) begin
    if (reset) begin
      beats0_r <= {STATS_W{1'b0}};
      beats1_r <= {STATS_W{1'b0}};
      pkts0_r  <= {STATS_W{1'b0}};
      pkts1_r  <= {STATS_W{1'b0}};
    end else begin
      if (bus.out0_valid && bus.out0_ready) begin
        beats0_r <= beats0_r + {{(STATS_W-1){1'b0}}, 1'b1};
        if (bus.out0_last) begin
          pkts0_r <= pkts0_r + {{(STATS_W-1){1'b0}}, 1'b1};
        end
      end
      if (bus.out1_valid && bus.out1_ready) begin
        beats1_r <= beats1_r + {{(STATS_W-1){1'b0}}, 1'b1};
        if (bus.out1_last) begin
          pkts1_r <= pkts1_r + {{(STATS_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  assign beats0 = beats0_r;
  assign beats1 = beats1_r;
  assign pkts0  = pkts0_r;
  assign pkts1  = pkts1_r;
`endif
endmodule

// File: tb/tb_demux_2_stream.sv
// Directed bench for demux_2_stream with a routing/slot model and per-port scoreboards.
module tb_demux_2_stream;
  import demux_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  demux_2_stream_if #(.data_width(16)) bus ();

`ifdef DEMUX_STATS_EN
  logic [15:0] beats0, beats1, pkts0, pkts1;
`endif

  demux_2_stream #(.data_width(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef DEMUX_STATS_EN
    ,
    .beats0 (beats0),
    .beats1 (beats1),
    .pkts0  (pkts0),
    .pkts1  (pkts1)
`endif
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: routing state, slot occupancy and expected slot contents.
  int          m_state = 0;
  bit          mv0 = 1'b0, mv1 = 1'b0;
  logic [16:0] q0[$];
  logic [16:0] q1[$];

  always @(negedge clk) begin
    logic m_dest, m_rdy, dr0, dr1, xf;
    if (reset) begin
      m_state = 0; mv0 = 1'b0; mv1 = 1'b0;
      q0.delete(); q1.delete();
    end else begin
      m_dest = (m_state == 0) ? bus.in_sel : (m_state == 2);
      m_rdy  = m_dest ? (!mv1 || bus.out1_ready) : (!mv0 || bus.out0_ready);
      chk("in_ready", {31'd0, bus.in_ready}, {31'd0, m_rdy});
      chk("out0_valid", {31'd0, bus.out0_valid}, {31'd0, mv0});
      chk("out1_valid", {31'd0, bus.out1_valid}, {31'd0, mv1});
      if (mv0) begin
        chk("sb0_size", q0.size(), 32'd1);
        if (q0.size() > 0) chk("out0_beat", {15'd0, bus.out0_last, bus.out0_data}, {15'd0, q0[0]});
      end
      if (mv1) begin
        chk("sb1_size", q1.size(), 32'd1);
        if (q1.size() > 0) chk("out1_beat", {15'd0, bus.out1_last, bus.out1_data}, {15'd0, q1[0]});
      end
      dr0 = mv0 && bus.out0_ready;
      dr1 = mv1 && bus.out1_ready;
      xf  = bus.in_valid && m_rdy;
      if (dr0 && q0.size() > 0) void'(q0.pop_front());
      if (dr1 && q1.size() > 0) void'(q1.pop_front());
      if (xf && !m_dest) q0.push_back({bus.in_last, bus.in_data});
      if (xf && m_dest)  q1.push_back({bus.in_last, bus.in_data});
      mv0 = (xf && !m_dest) ? 1'b1 : (dr0 ? 1'b0 : mv0);
      mv1 = (xf && m_dest)  ? 1'b1 : (dr1 ? 1'b0 : mv1);
      if (xf) begin
        if (bus.in_last) m_state = 0;
        else if (m_state == 0) m_state = bus.in_sel ? 2 : 1;
      end
    end
  end

  // Present one beat and hold it until accepted (bounded).
  task automatic send(input logic s, input logic [15:0] d, input logic l);
    int   n = 0;
    logic acc;
    bus.in_valid = 1'b1; bus.in_sel = s; bus.in_data = d; bus.in_last = l;
    do begin
      @(negedge clk); acc = bus.in_ready;
      @(posedge clk); #1; n++;
    end while (!acc && n < 50);
    if (!acc) chk("send_timeout", {31'd0, acc}, 32'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    int t0;
    bus.in_valid = 1'b0; bus.in_sel = 1'b0; bus.in_data = 16'h0000; bus.in_last = 1'b0;
    bus.out0_ready = 1'b1; bus.out1_ready = 1'b1;

    // Reset state
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("rst_out0_valid", {31'd0, bus.out0_valid}, 32'd0);
    chk("rst_out1_valid", {31'd0, bus.out1_valid}, 32'd0);
    chk("rst_out0_data", {16'd0, bus.out0_data}, 32'd0);
    chk("rst_out1_last", {31'd0, bus.out1_last}, 32'd0);
    chk("rst_state", {30'd0, dut.state_r}, {30'd0, IDLE});
`ifdef DEMUX_STATS_EN
    chk("rst_beats0", {16'd0, beats0}, 32'd0);
`endif
    @(posedge clk); #1; reset = 1'b0;
    idle(1);

    // Single-beat packets
    send(1'b0, 16'h1234, 1'b1);
    @(negedge clk);
    chk("t1_out0_valid", {31'd0, bus.out0_valid}, 32'd1);
    chk("t1_out0_data", {16'd0, bus.out0_data}, 32'h1234);
    chk("t1_state_a", {30'd0, dut.state_r}, {30'd0, IDLE});
    @(posedge clk); #1;
    send(1'b1, 16'hABCD, 1'b1);
    @(negedge clk);
    chk("t1_out1_data", {16'd0, bus.out1_data}, 32'hABCD);
    chk("t1_out1_last", {31'd0, bus.out1_last}, 32'd1);
    chk("t1_state_b", {30'd0, dut.state_r}, {30'd0, IDLE});
    @(posedge clk); #1;
    idle(2);

    // Packet lock: in_sel toggles after the first beat but route stays on out0
    send(1'b0, 16'h0001, 1'b0);
    chk("t2_state_route0", {30'd0, dut.state_r}, {30'd0, ROUTE0});
    send(1'b1, 16'h0002, 1'b0);
    send(1'b1, 16'h0003, 1'b0);
    send(1'b1, 16'h0004, 1'b1);
    @(negedge clk);
    chk("t2_out0_data", {16'd0, bus.out0_data}, 32'h0004);
    chk("t2_out0_last", {31'd0, bus.out0_last}, 32'd1);
    chk("t2_out1_valid", {31'd0, bus.out1_valid}, 32'd0);
    @(posedge clk); #1;
    idle(2);

    // Backpressure on out0, then replace-on-drain without a bubble
    bus.out0_ready = 1'b0;
    send(1'b0, 16'h00AA, 1'b1);
    bus.in_valid = 1'b1; bus.in_sel = 1'b0; bus.in_data = 16'h00BB; bus.in_last = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("t3_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
      chk("t3_out0_hold", {16'd0, bus.out0_data}, 32'h00AA);
      @(posedge clk); #1;
    end
    bus.out0_ready = 1'b1;
    @(negedge clk);
    chk("t3_in_ready_high", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("t3_no_bubble_valid", {31'd0, bus.out0_valid}, 32'd1);
    chk("t3_no_bubble_data", {16'd0, bus.out0_data}, 32'h00BB);
    @(posedge clk); #1;
    idle(2);

    // Independent drain: out1 stalled while out0 streams at full rate
    bus.out1_ready = 1'b0;
    send(1'b1, 16'h5555, 1'b1);
    t0 = cyc;
    send(1'b0, 16'h0101, 1'b0);
    send(1'b0, 16'h0202, 1'b0);
    send(1'b0, 16'h0303, 1'b1);
    chk("t4_full_rate", t0 + 3, cyc);
    @(negedge clk);
    chk("t4_out1_retained", {16'd0, bus.out1_data}, 32'h5555);
    chk("t4_out1_valid", {31'd0, bus.out1_valid}, 32'd1);
    @(posedge clk); #1;
    bus.out1_ready = 1'b1;
    idle(3);

    // Reset mid-packet in ROUTE1
    send(1'b1, 16'h00A1, 1'b0);
    send(1'b1, 16'h00A2, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("t5_out0_valid", {31'd0, bus.out0_valid}, 32'd0);
    chk("t5_out1_valid", {31'd0, bus.out1_valid}, 32'd0);
    chk("t5_state", {30'd0, dut.state_r}, {30'd0, IDLE});
    @(posedge clk); #1;
    send(1'b0, 16'h00C0, 1'b1);
    @(negedge clk);
    chk("t5_out0_data", {16'd0, bus.out0_data}, 32'h00C0);
    chk("t5_out1_idle", {31'd0, bus.out1_valid}, 32'd0);
    @(posedge clk); #1;
    idle(2);

`ifdef DEMUX_STATS_EN
    // Counters: 3 two-beat packets to out1, then wrap beats1
    reset = 1'b1; idle(1); reset = 1'b0; idle(1);
    for (int p = 0; p < 3; p++) begin
      send(1'b1, 16'h1000 + 16'(p), 1'b0);
      send(1'b1, 16'h2000 + 16'(p), 1'b1);
    end
    idle(2);
    @(negedge clk);
    chk("st_beats1", {16'd0, beats1}, 32'd6);
    chk("st_pkts1", {16'd0, pkts1}, 32'd3);
    chk("st_beats0", {16'd0, beats0}, 32'd0);
    chk("st_pkts0", {16'd0, pkts0}, 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 65530; i++) send(1'b1, 16'(i), 1'b0);
    idle(2);
    @(negedge clk);
    chk("st_beats1_wrap", {16'd0, beats1}, 32'd0);
    @(posedge clk); #1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
